tick_delay_timer: RTL and testbench

- Consumer of the 1 µs (`us_tck`) and 1 ms (`ms_tck`) strobes produced by the clock-generation block.
- Provides a programmable one-shot or periodic delay, counted in µs or ms units, with a start/done handshake.
- Used by camera power-up/reset sequencing and SCCB/I2C retry back-off, so those blocks do not each carry their own wide cycle counters.
- Sits in the `pll_outclk_0` domain beside the clock-generation block.

---
 rtl/tick_delay_timer.sv | 104 ++++++++++
 tb/tb_tick_delay_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_delay_timer.sv
// Purpose : programmable one-shot / periodic delay counted in us_tck or ms_tck strobes.
// Latency : done and the updated remaining appear one clock after the edge that samples the terminal tick.
// Backpres: none; start/abort are accepted on any cycle (rst > abort > start > tick).
//
// Ports:
//   pll_outclk_0        clock, rising edge
//   rst                 synchronous, active-low reset
//   us_tck / ms_tck     free-running 1-cycle tick strobes (1 us / 1 ms)
//   start / abort       launch (latches delay/unit/periodic) / cancel without done
//   unit                0 = count us_tck, 1 = count ms_tck
//   periodic            0 = one-shot, 1 = auto-reload on expiry
//   delay               interval length in ticks of the selected unit
//   busy                high while an interval is running
//   done                1-cycle pulse at each interval expiry
//   expired             sticky one-shot completion flag, cleared by start/abort
//   remaining           ticks left in the current interval
module tick_delay_timer #(
    parameter int CNT_W = 16
) (
    input  logic             pll_outclk_0,
    input  logic             rst,
    input  logic             us_tck,
    input  logic             ms_tck,
    input  logic             start,
    input  logic             abort,
    input  logic             unit,
    input  logic             periodic,
    input  logic [CNT_W-1:0] delay,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic             r_done;
    logic             r_expired;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_shadow_delay;
    logic             r_shadow_unit;
    logic             r_shadow_periodic;

    logic             w_tick;
    logic             w_last;

    // Only the strobe chosen at start counts; the other one is ignored.
    assign w_tick = r_shadow_unit ? ms_tck : us_tck;
    assign w_last = (r_remaining == CNT_W'(1));

    always_ff @(posedge pll_outclk_0) begin
        r_done <= 1'b0;
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_expired         <= 1'b0;
            r_remaining       <= '0;
            r_shadow_delay    <= '0;
            r_shadow_unit     <= 1'b0;
            r_shadow_periodic <= 1'b0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_expired   <= 1'b0;
            r_remaining <= '0;
        end else if (start) begin
            // A start also pre-empts a terminal tick in the same cycle, so the
            // old interval ends silently.
            r_shadow_delay    <= delay;
            r_shadow_unit     <= unit;
            r_shadow_periodic <= periodic;
            if (delay != '0) begin
                r_state     <= ST_RUN;
                r_expired   <= 1'b0;
                r_remaining <= delay;
            end else begin
                // Zero-length interval completes immediately, never reloads.
                r_state     <= ST_IDLE;
                r_done      <= 1'b1;
                r_expired   <= 1'b1;
                r_remaining <= '0;
            end
        end else if ((r_state == ST_RUN) && w_tick) begin
            if (w_last) begin
                r_done <= 1'b1;
                if (r_shadow_periodic) begin
                    r_remaining <= r_shadow_delay;
                end else begin
                    r_state     <= ST_IDLE;
                    r_expired   <= 1'b1;
                    r_remaining <= '0;
                end
            end else if (r_remaining != '0) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign expired   = r_expired;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_tick_delay_timer.sv
module tb_tick_delay_timer;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic             busy;
        logic             expired;
        logic [CNT_W-1:0] rem;
    } exp_t;

    logic             pll_outclk_0;
    logic             rst;
    logic             us_tck;
    logic             ms_tck;
    logic             start;
    logic             abort;
    logic             unit;
    logic             periodic;
    logic [CNT_W-1:0] delay;
    logic             busy;
    logic             done;
    logic             expired;
    logic [CNT_W-1:0] remaining;

    int   checks;
    int   errors;
    int   done_cnt;
    exp_t sb_q[$];

    tick_delay_timer #(.CNT_W(CNT_W)) dut (
        .pll_outclk_0 (pll_outclk_0),
        .rst          (rst),
        .us_tck       (us_tck),
        .ms_tck       (ms_tck),
        .start        (start),
        .abort        (abort),
        .unit         (unit),
        .periodic     (periodic),
        .delay        (delay),
        .busy         (busy),
        .done         (done),
        .expired      (expired),
        .remaining    (remaining)
    );

    initial pll_outclk_0 = 1'b0;
    always #5 pll_outclk_0 = ~pll_outclk_0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected record.
    always @(negedge pll_outclk_0) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("done_busy", {31'd0, busy}, {31'd0, e.busy});
                chk("done_expired", {31'd0, expired}, {31'd0, e.expired});
                chk("done_remaining", {16'd0, remaining}, {16'd0, e.rem});
            end
        end
    end

    task automatic clk1();
        @(posedge pll_outclk_0);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) clk1();
    endtask

    task automatic pulse_us();
        us_tck = 1'b1;
        clk1();
        us_tck = 1'b0;
    endtask

    task automatic pulse_ms();
        ms_tck = 1'b1;
        clk1();
        ms_tck = 1'b0;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] d, input logic u, input logic p);
        delay    = d;
        unit     = u;
        periodic = p;
        start    = 1'b1;
        clk1();
        start    = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic b, input logic x,
                             input logic [CNT_W-1:0] r);
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_expired"}, {31'd0, expired}, {31'd0, x});
        chk({name, "_remaining"}, {16'd0, remaining}, {16'd0, r});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1 ms");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst = 1'b0; us_tck = 1'b0; ms_tck = 1'b0; start = 1'b0; abort = 1'b0;
        unit = 1'b0; periodic = 1'b0; delay = '0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 3; i++) begin
            us_tck   = 1'($urandom);
            ms_tck   = 1'($urandom);
            start    = 1'($urandom);
            abort    = 1'($urandom);
            unit     = 1'($urandom);
            periodic = 1'($urandom);
            delay    = CNT_W'($urandom);
            clk1();
            chk_state("reset", 1'b0, 1'b0, '0);
            chk("reset_done", {31'd0, done}, 32'd0);
        end
        us_tck = 1'b0; ms_tck = 1'b0; start = 1'b0; abort = 1'b0;
        unit = 1'b0; periodic = 1'b0; delay = '0;
        rst = 1'b1;
        clk1();
        chk_state("post_reset", 1'b0, 1'b0, '0);
        chk("post_reset_done", {31'd0, done}, 32'd0);

        // One-shot, us units, delay 5; ms strobes in between must be ignored.
        do_start(16'd5, 1'b0, 1'b0);
        chk_state("os_start", 1'b1, 1'b0, 16'd5);
        for (int k = 1; k <= 5; k++) begin
            idle_n(20);
            pulse_ms();
            chk("os_ms_ignored", {16'd0, remaining}, 32'(6 - k));
            idle_n(28);
            if (k == 5) sb_q.push_back('{busy: 1'b0, expired: 1'b1, rem: '0});
            pulse_us();
            chk("os_step", {16'd0, remaining}, 32'(5 - k));
        end
        chk_state("os_end", 1'b0, 1'b1, '0);
        idle_n(3);
        chk("os_done_count", done_cnt, 32'd1);

        // Periodic, ms units, delay 3, ten strobes; us strobes ignored.
        do_start(16'd3, 1'b1, 1'b1);
        chk_state("per_start", 1'b1, 1'b0, 16'd3);
        for (int k = 1; k <= 10; k++) begin
            idle_n(10);
            pulse_us();
            idle_n(9);
            if (k % 3 == 0) sb_q.push_back('{busy: 1'b1, expired: 1'b0, rem: 16'd3});
            pulse_ms();
            chk_state("per_step", 1'b1, 1'b0, (k % 3 == 0) ? 16'd3 : 16'(3 - k % 3));
        end
        idle_n(2);
        chk("per_done_count", done_cnt, 32'd4);
        abort = 1'b1;
        clk1();
        abort = 1'b0;
        chk_state("per_abort", 1'b0, 1'b0, '0);

        // Zero delay: immediate done, never busy, no reload even if periodic.
        sb_q.push_back('{busy: 1'b0, expired: 1'b1, rem: '0});
        do_start(16'd0, 1'b0, 1'b1);
        chk_state("zero", 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            pulse_us();
            chk("zero_busy", {31'd0, busy}, 32'd0);
        end
        chk("zero_done_count", done_cnt, 32'd5);

        // Start coincident with the terminal tick of a delay=2 run.
        do_start(16'd2, 1'b0, 1'b0);
        chk_state("col_start", 1'b1, 1'b0, 16'd2);
        idle_n(5);
        pulse_us();
        chk("col_rem1", {16'd0, remaining}, 32'd1);
        idle_n(5);
        us_tck = 1'b1;
        do_start(16'd7, 1'b0, 1'b0);
        us_tck = 1'b0;
        chk_state("col_restart", 1'b1, 1'b0, 16'd7);

        // Abort wins over a simultaneous start.
        abort = 1'b1;
        do_start(16'd9, 1'b0, 1'b0);
        abort = 1'b0;
        chk_state("abort_start", 1'b0, 1'b0, '0);

        // Reset in the middle of a run.
        do_start(16'd6, 1'b0, 1'b0);
        pulse_us();
        idle_n(3);
        pulse_us();
        chk("mid_rem4", {16'd0, remaining}, 32'd4);
        rst = 1'b0;
        clk1();
        rst = 1'b1;
        chk_state("mid_reset", 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            idle_n(4);
            pulse_us();
            chk_state("mid_after", 1'b0, 1'b0, '0);
        end

        idle_n(3);
        chk("final_done_count", done_cnt, 32'd5);
        chk("final_queue_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
